// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the single-channel word-copy DMA engine:
//   - register offsets as decoded from addr_i[3:2]
//   - bit positions inside the CTRL register
//   - FSM state encoding used by dma_copy
//   - a helper that expands the byte-lane select into a 32-bit bit mask
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_IE    = 3;
    localparam int CTRL_ABORT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } dma_state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/dma_regs.sv
// -----------------------------------------------------------------------------
// dma_regs
// Register-port front end of the DMA engine. Decodes register accesses,
// merges write data into the current register value according to the byte
// lanes, produces one-cycle command strobes for CTRL, and returns registered
// read data with a one-cycle acknowledge. The registers themselves live in
// dma_copy because the copy datapath updates them.
//
// Ports:
//   clk_i, n_rst_i          clock, asynchronous active-low reset
//   ce_i/sel_i/addr_i/we_i/data_i   register access from the core
//   rvalid_o, data_o        acknowledge and read data (one cycle after ce_i)
//   i_src/i_dst/i_len       live register values (for merging and read back)
//   i_busy/i_done/i_ie      status bits for CTRL read back
//   o_*_we, o_*_wdata       register updates (gated off while busy)
//   o_start/o_abort/o_done_clr/o_ie_we/o_ie_wdata   CTRL command strobes
// -----------------------------------------------------------------------------
module dma_regs
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             ce_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [31:0]      data_i,
    output logic             rvalid_o,
    output logic [31:0]      data_o,
    input  logic [31:0]      i_src,
    input  logic [31:0]      i_dst,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_busy,
    input  logic             i_done,
    input  logic             i_ie,
    output logic             o_src_we,
    output logic [31:0]      o_src_wdata,
    output logic             o_dst_we,
    output logic [31:0]      o_dst_wdata,
    output logic             o_len_we,
    output logic [LEN_W-1:0] o_len_wdata,
    output logic             o_start,
    output logic             o_abort,
    output logic             o_done_clr,
    output logic             o_ie_we,
    output logic             o_ie_wdata
);

    logic [1:0]  w_regSel;
    logic [31:0] w_mask;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrlWr;
    logic [31:0] w_rdData;
    logic        w_unused_addr;

    assign w_regSel      = addr_i[3:2];
    assign w_mask        = lane_mask(sel_i);
    assign w_wr          = ce_i & we_i;
    assign w_rd          = ce_i & ~we_i;
    assign w_unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    // Address/count registers are frozen while a transfer is running; the
    // low two address bits are forced to zero so transfers stay word aligned.
    assign o_src_we    = w_wr && (w_regSel == REG_SRC) && !i_busy;
    assign o_dst_we    = w_wr && (w_regSel == REG_DST) && !i_busy;
    assign o_len_we    = w_wr && (w_regSel == REG_LEN) && !i_busy;
    assign o_src_wdata = ((i_src & ~w_mask) | (data_i & w_mask)) & 32'hFFFF_FFFC;
    assign o_dst_wdata = ((i_dst & ~w_mask) | (data_i & w_mask)) & 32'hFFFF_FFFC;
    assign o_len_wdata = (i_len & ~w_mask[LEN_W-1:0]) | (data_i[LEN_W-1:0] & w_mask[LEN_W-1:0]);

    // All CTRL bits sit in byte lane 0, so only that lane carries commands.
    assign w_ctrlWr   = w_wr && (w_regSel == REG_CTRL) && sel_i[0];
    assign o_start    = w_ctrlWr & data_i[CTRL_START];
    assign o_abort    = w_ctrlWr & data_i[CTRL_ABORT];
    assign o_done_clr = w_ctrlWr & data_i[CTRL_DONE];
    assign o_ie_we    = w_ctrlWr;
    assign o_ie_wdata = data_i[CTRL_IE];

    // Read mux; START and ABORT are command bits and always read as zero.
    always_comb begin
        w_rdData = '0;
        case (w_regSel)
            REG_SRC:  w_rdData = i_src;
            REG_DST:  w_rdData = i_dst;
            REG_LEN:  w_rdData = 32'(i_len);
            REG_CTRL: begin
                w_rdData[CTRL_BUSY] = i_busy;
                w_rdData[CTRL_DONE] = i_done;
                w_rdData[CTRL_IE]   = i_ie;
            end
            default:  w_rdData = '0;
        endcase
    end

    // Every access is acknowledged one cycle later; data_o only carries
    // read data during a read acknowledge and is zero otherwise.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            rvalid_o <= 1'b0;
            data_o   <= '0;
        end else begin
            rvalid_o <= ce_i;
            data_o   <= w_rd ? w_rdData : '0;
        end
    end

endmodule

// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy
// Single-channel word-copy DMA engine. The core programs SRC, DST and LEN
// through the register port and writes START; the engine then reads one word
// from SRC, writes it to DST, advances both addresses by 4 and decrements LEN
// until LEN reaches zero, using the same req/sel/addr/we/data/rvalid protocol
// as the core's LSU.
//
// Configuration macro: DMA_IRQ_EN
//   defined   - CTRL.IE is read/write and irq_o = DONE & IE
//   undefined - CTRL.IE reads 0 and irq_o is tied 0 (DONE is still polled)
//
// Ports:
//   clk_i, n_rst_i          clock, asynchronous active-low reset
//   ce_i ... data_o         register slave port (see dma_regs)
//   m_req_o ... m_data_i    bus master port
//   irq_o                   level interrupt
// -----------------------------------------------------------------------------
module dma_copy
    import dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        ce_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    output logic        rvalid_o,
    output logic [31:0] data_o,
    output logic        m_req_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_addr_o,
    output logic        m_we_o,
    output logic [31:0] m_data_o,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_data_i,
    output logic        irq_o
);

    dma_state_t       r_state;
    dma_state_t       w_nextState;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_lenNext;
    logic             r_done;
    logic             r_abort;
    logic             w_ie;
    logic             w_busy;
    logic             w_beat;
    logic             w_lastBeat;
    logic             w_stop;
    logic             w_setDone;

    logic             w_srcWe;
    logic             w_dstWe;
    logic             w_lenWe;
    logic [31:0]      w_srcWdata;
    logic [31:0]      w_dstWdata;
    logic [LEN_W-1:0] w_lenWdata;
    logic             w_start;
    logic             w_abort;
    logic             w_doneClr;
    logic             w_ieWe;
    logic             w_ieWdata;

    dma_regs #(
        .LEN_W (LEN_W)
    ) u_regs (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .ce_i        (ce_i),
        .sel_i       (sel_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .data_i      (data_i),
        .rvalid_o    (rvalid_o),
        .data_o      (data_o),
        .i_src       (r_src),
        .i_dst       (r_dst),
        .i_len       (r_len),
        .i_busy      (w_busy),
        .i_done      (r_done),
        .i_ie        (w_ie),
        .o_src_we    (w_srcWe),
        .o_src_wdata (w_srcWdata),
        .o_dst_we    (w_dstWe),
        .o_dst_wdata (w_dstWdata),
        .o_len_we    (w_lenWe),
        .o_len_wdata (w_lenWdata),
        .o_start     (w_start),
        .o_abort     (w_abort),
        .o_done_clr  (w_doneClr),
        .o_ie_we     (w_ieWe),
        .o_ie_wdata  (w_ieWdata)
    );

`ifdef DMA_IRQ_EN
    logic r_ie;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_ie <= 1'b0;
        end else if (w_ieWe) begin
            r_ie <= w_ieWdata;
        end
    end

    assign w_ie = r_ie;
`else
    logic w_unused_ie;

    assign w_unused_ie = w_ieWe ^ w_ieWdata;
    assign w_ie        = 1'b0;
`endif

    assign irq_o = r_done & w_ie;

    assign w_busy     = (r_state != ST_IDLE);
    assign w_beat     = (r_state == ST_WR);
    assign w_lenNext  = r_len - LEN_W'(1);
    assign w_lastBeat = w_beat && (w_lenNext == '0);
    // An abort is only honoured once the current write beat has gone out,
    // so a word that has been read is always also written.
    assign w_stop     = w_beat && (w_lastBeat || r_abort || w_abort);
    // A zero-length START completes immediately without touching the bus.
    assign w_setDone  = w_lastBeat || ((r_state == ST_IDLE) && w_start && (r_len == '0));

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and bus outputs; the bus outputs are decoded straight from
    // the state register so an asynchronous reset drops the request at once.
    always_comb begin
        w_nextState = r_state;
        m_req_o     = 1'b0;
        m_sel_o     = 4'b0000;
        m_addr_o    = '0;
        m_we_o      = 1'b0;
        m_data_o    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start && (r_len != '0)) begin
                    w_nextState = ST_RD;
                end
            end
            ST_RD: begin
                m_req_o  = 1'b1;
                m_sel_o  = 4'b1111;
                m_addr_o = r_src;
                if (m_rvalid_i) begin
                    w_nextState = ST_WR;
                end
            end
            ST_WR: begin
                m_req_o     = 1'b1;
                m_sel_o     = 4'b1111;
                m_addr_o    = r_dst;
                m_we_o      = 1'b1;
                m_data_o    = r_data;
                w_nextState = w_stop ? ST_IDLE : ST_RD;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Address/count datapath: programmed while idle, advanced after every
    // write beat. Address arithmetic wraps modulo 2^32.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_src  <= '0;
            r_dst  <= '0;
            r_len  <= '0;
            r_data <= '0;
        end else begin
            if (w_srcWe) begin
                r_src <= w_srcWdata;
            end else if (w_beat) begin
                r_src <= r_src + 32'd4;
            end
            if (w_dstWe) begin
                r_dst <= w_dstWdata;
            end else if (w_beat) begin
                r_dst <= r_dst + 32'd4;
            end
            if (w_lenWe) begin
                r_len <= w_lenWdata;
            end else if (w_beat) begin
                r_len <= w_lenNext;
            end
            if ((r_state == ST_RD) && m_rvalid_i) begin
                r_data <= m_data_i;
            end
        end
    end

    // DONE is sticky; a hardware set wins over a simultaneous clear.
    // The abort request is remembered until the end of the current beat.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (w_setDone) begin
                r_done <= 1'b1;
            end else if (w_doneClr) begin
                r_done <= 1'b0;
            end
            if (!w_busy || w_stop) begin
                r_abort <= 1'b0;
            end else if (w_abort) begin
                r_abort <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_dma_copy
// Self-checking bench for dma_copy. A bus slave with configurable read
// latency serves the master port and logs every read and write beat; each
// test programs a transfer and compares the logs and register read back
// against word lists computed directly from SRC/DST/LEN.
// Honours DMA_IRQ_EN for the interrupt expectations.
// -----------------------------------------------------------------------------
module tb_dma_copy;

`ifdef DMA_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        ce_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] data_i;
    logic        rvalid_o;
    logic [31:0] data_o;
    logic        m_req_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [31:0] m_data_o;
    logic        m_rvalid_i;
    logic [31:0] m_data_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] readLog[$];
    logic [31:0] writeAddrLog[$];
    logic [31:0] writeDataLog[$];
    logic [31:0] expData[$];
    int          readLatency = 1;
    int          waitCnt = 0;
    int          reqCycles = 0;
    int          selErrors = 0;
    int          stableErrors = 0;
    logic        prevRdWait = 1'b0;
    logic [31:0] prevAddr = '0;
    logic [31:0] ieBits = '0;

    dma_copy #(.LEN_W(16)) dut (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .ce_i       (ce_i),
        .sel_i      (sel_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .data_i     (data_i),
        .rvalid_o   (rvalid_o),
        .data_o     (data_o),
        .m_req_o    (m_req_o),
        .m_sel_o    (m_sel_o),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_data_o   (m_data_o),
        .m_rvalid_i (m_rvalid_i),
        .m_data_i   (m_data_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Bus slave: rvalid after readLatency wait cycles, writes take one cycle.
    always @(negedge clk_i) begin
        if (!n_rst_i) begin
            m_rvalid_i = 1'b0;
            m_data_i   = '0;
            waitCnt    = 0;
            prevRdWait = 1'b0;
        end else begin
            if (m_req_o) begin
                reqCycles++;
                if (m_sel_o !== 4'hF) selErrors++;
            end
            if (m_req_o && !m_we_o) begin
                if (prevRdWait && (m_addr_o !== prevAddr)) stableErrors++;
                if (waitCnt == readLatency) begin
                    m_rvalid_i = 1'b1;
                    m_data_i   = memRead(m_addr_o);
                    readLog.push_back(m_addr_o);
                    waitCnt    = 0;
                    prevRdWait = 1'b0;
                end else begin
                    m_rvalid_i = 1'b0;
                    waitCnt++;
                    prevRdWait = 1'b1;
                    prevAddr   = m_addr_o;
                end
            end else begin
                m_rvalid_i = 1'b0;
                m_data_i   = '0;
                waitCnt    = 0;
                prevRdWait = 1'b0;
                if (m_req_o && m_we_o) begin
                    mem[m_addr_o] = m_data_o;
                    writeAddrLog.push_back(m_addr_o);
                    writeDataLog.push_back(m_data_o);
                end
            end
        end
    end

    task automatic regWrite(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk_i);
        ce_i = 1'b1; we_i = 1'b1; addr_i = {28'h0, idx, 2'b00}; data_i = d; sel_i = s;
        @(negedge clk_i);
        ce_i = 1'b0; we_i = 1'b0; data_i = '0; sel_i = '0;
    endtask

    task automatic regRead(input logic [1:0] idx, output logic [31:0] d, output logic v);
        @(negedge clk_i);
        ce_i = 1'b1; we_i = 1'b0; addr_i = {28'h0, idx, 2'b00}; sel_i = '0;
        @(negedge clk_i);
        ce_i = 1'b0;
        d = data_o;
        v = rvalid_o;
    endtask

    task automatic fillSource(input logic [31:0] src, input int len);
        expData.delete();
        for (int i = 0; i < len; i++) begin
            logic [31:0] w;
            w = $urandom;
            mem[src + 32'(4 * i)] = w;
            expData.push_back(w);
        end
    endtask

    // Programs a transfer and writes START; returns one cycle after START.
    task automatic startCopy(input logic [31:0] src, input logic [31:0] dst, input int len, input int lat);
        readLatency = lat;
        regWrite(2'd0, src, 4'hF);
        regWrite(2'd1, dst, 4'hF);
        regWrite(2'd2, 32'(len), 4'hF);
        regWrite(2'd3, 32'h4 | ieBits, 4'hF);
        readLog.delete();
        writeAddrLog.delete();
        writeDataLog.delete();
        reqCycles = 0;
        regWrite(2'd3, 32'h1 | ieBits, 4'hF);
    endtask

    task automatic waitIdle(input int budget, output int cycles);
        cycles = 0;
        while (m_req_o && cycles < budget) begin
            @(negedge clk_i);
            cycles++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic v;
        n_rst_i = 1'b0; ce_i = 0; we_i = 0; sel_i = 0; addr_i = 0; data_i = 0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({m_req_o, m_sel_o, m_addr_o, m_we_o, m_data_o, rvalid_o, data_o, irq_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b sel=%h addr=%h we=%b data=%h rvalid=%b rdata=%h irq=%b, expected all 0",
                     m_req_o, m_sel_o, m_addr_o, m_we_o, m_data_o, rvalid_o, data_o, irq_o);
        end
        n_rst_i = 1'b1;
        for (int r = 0; r < 4; r++) begin
            regRead(2'(r), d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_reg%0d: got %h (rvalid %b), expected 00000000 (rvalid 1)", r, d, v);
            end
        end
    endtask

    task automatic test_regport;
        logic [31:0] d;
        logic v;
        regWrite(2'd0, 32'h1234_5677, 4'hF);
        checks++;
        if (rvalid_o !== 1'b1 || data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_ack: got rvalid=%b data=%h, expected rvalid=1 data=0", rvalid_o, data_o);
        end
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h1234_5674) begin
            errors++;
            $display("[TB] FAIL src_align: got %h, expected 12345674", d);
        end
        @(negedge clk_i);
        checks++;
        if (rvalid_o !== 1'b0 || data_o !== 32'h0) begin
            errors++;
            $display("[TB] FAIL idle_port: got rvalid=%b data=%h, expected 0/0", rvalid_o, data_o);
        end
        regWrite(2'd0, 32'hAABB_CCDD, 4'b0010);
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h1234_CC74) begin
            errors++;
            $display("[TB] FAIL src_lanes: got %h, expected 1234cc74", d);
        end
        regWrite(2'd1, 32'hFFFF_FFFF, 4'b1001);
        regRead(2'd1, d, v);
        checks++;
        if (d !== 32'hFF00_00FC) begin
            errors++;
            $display("[TB] FAIL dst_lanes: got %h, expected ff0000fc", d);
        end
        regWrite(2'd2, 32'hFFFF_FFFF, 4'hF);
        regWrite(2'd2, 32'h0000_0000, 4'b0001);
        regRead(2'd2, d, v);
        checks++;
        if (d !== 32'h0000_FF00) begin
            errors++;
            $display("[TB] FAIL len_lanes: got %h, expected 0000ff00", d);
        end
        regWrite(2'd3, 32'h8, 4'hF);
        regRead(2'd3, d, v);
        checks++;
        if (d !== (IRQ_EN ? 32'h8 : 32'h0)) begin
            errors++;
            $display("[TB] FAIL ie_rw: got %h, expected %h", d, IRQ_EN ? 32'h8 : 32'h0);
        end
        regWrite(2'd3, 32'h0, 4'hF);
    endtask

    task automatic test_copy;
        logic [31:0] d;
        logic v;
        int cyc;
        fillSource(32'h1000_0000, 4);
        startCopy(32'h1000_0000, 32'h1000_0100, 4, 1);
        checks++;
        if (m_req_o !== 1'b1 || m_we_o !== 1'b0 || m_addr_o !== 32'h1000_0000) begin
            errors++;
            $display("[TB] FAIL start_latency: got req=%b we=%b addr=%h, expected 1/0/10000000", m_req_o, m_we_o, m_addr_o);
        end
        waitIdle(200, cyc);
        checks++;
        if (cyc !== 12) begin
            errors++;
            $display("[TB] FAIL copy_cycles: got %0d, expected 12", cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (readLog.size() <= i || writeAddrLog.size() <= i ||
                readLog[i] !== 32'h1000_0000 + 32'(4 * i) ||
                writeAddrLog[i] !== 32'h1000_0100 + 32'(4 * i) ||
                writeDataLog[i] !== expData[i]) begin
                errors++;
                $display("[TB] FAIL copy_word%0d: got beats r=%0d w=%0d, expected addr %h->%h data %h",
                         i, readLog.size(), writeAddrLog.size(), 32'h1000_0000 + 32'(4 * i),
                         32'h1000_0100 + 32'(4 * i), expData[i]);
            end
        end
        regRead(2'd3, d, v);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("[TB] FAIL copy_ctrl: got %h, expected 00000004", d);
        end
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h1000_0010) begin
            errors++;
            $display("[TB] FAIL copy_src_final: got %h, expected 10000010", d);
        end
    endtask

    task automatic test_len_zero;
        logic [31:0] d;
        logic v;
        regWrite(2'd3, 32'h4, 4'hF);
        regWrite(2'd2, 32'h0, 4'hF);
        reqCycles = 0;
        regWrite(2'd3, 32'h1, 4'hF);
        regRead(2'd3, d, v);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("[TB] FAIL len0_ctrl: got %h, expected 00000004 (DONE, not BUSY)", d);
        end
        repeat (4) @(negedge clk_i);
        checks++;
        if (reqCycles !== 0) begin
            errors++;
            $display("[TB] FAIL len0_bus: got %0d request cycles, expected 0", reqCycles);
        end
    endtask

    task automatic test_busy_writes;
        logic [31:0] d;
        logic v;
        int cyc;
        fillSource(32'h3000_0040, 2);
        stableErrors = 0;
        startCopy(32'h3000_0040, 32'h3000_0800, 2, 5);
        regWrite(2'd3, 32'h1, 4'hF);
        regWrite(2'd0, 32'hDEAD_0000, 4'hF);
        regWrite(2'd2, 32'h55, 4'hF);
        waitIdle(200, cyc);
        repeat (4) @(negedge clk_i);
        checks++;
        if (reqCycles !== 14 || stableErrors !== 0) begin
            errors++;
            $display("[TB] FAIL busy_bus: got %0d request cycles and %0d address changes, expected 14 and 0", reqCycles, stableErrors);
        end
        checks++;
        if (writeAddrLog.size() !== 2 || readLog[0] !== 32'h3000_0040 || readLog[1] !== 32'h3000_0044 ||
            writeDataLog[0] !== expData[0] || writeDataLog[1] !== expData[1]) begin
            errors++;
            $display("[TB] FAIL busy_words: got %0d writes, expected 2 words from 30000040", writeAddrLog.size());
        end
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h3000_0048) begin
            errors++;
            $display("[TB] FAIL busy_src: got %h, expected 30000048", d);
        end
        regRead(2'd2, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL busy_len: got %h, expected 00000000", d);
        end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        logic v;
        int cyc;
        int guard;
        fillSource(32'h4000_0000, 8);
        startCopy(32'h4000_0000, 32'h4000_1000, 8, 2);
        guard = 0;
        while (!(writeAddrLog.size() == 1 && m_req_o && !m_we_o) && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            errors++;
            $display("[TB] FAIL abort_sync: got timeout, expected RD of word 2");
        end
        regWrite(2'd3, 32'h10, 4'hF);
        waitIdle(200, cyc);
        checks++;
        if (m_req_o !== 1'b0 || writeAddrLog.size() !== 2 || writeDataLog[1] !== expData[1]) begin
            errors++;
            $display("[TB] FAIL abort_beats: got req=%b writes=%0d, expected 0 and 2", m_req_o, writeAddrLog.size());
        end
        regRead(2'd2, d, v);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("[TB] FAIL abort_len: got %h, expected 00000006", d);
        end
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h4000_0008) begin
            errors++;
            $display("[TB] FAIL abort_src: got %h, expected 40000008", d);
        end
        regRead(2'd3, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("[TB] FAIL abort_ctrl: got %h, expected 00000000", d);
        end
        // ABORT while idle does nothing; resuming finishes the remaining words.
        regWrite(2'd3, 32'h10, 4'hF);
        regWrite(2'd3, 32'h1, 4'hF);
        waitIdle(200, cyc);
        regRead(2'd3, d, v);
        checks++;
        if (d !== 32'h4 || writeAddrLog.size() !== 8 || writeDataLog[7] !== expData[7] ||
            writeAddrLog[7] !== 32'h4000_101C) begin
            errors++;
            $display("[TB] FAIL abort_resume: got ctrl=%h writes=%0d, expected 00000004 and 8", d, writeAddrLog.size());
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic v;
        int cyc;
        fillSource(32'hFFFF_FFF8, 3);
        startCopy(32'hFFFF_FFF8, 32'h2000_0000, 3, 0);
        waitIdle(200, cyc);
        checks++;
        if (readLog.size() !== 3 || readLog[0] !== 32'hFFFF_FFF8 || readLog[1] !== 32'hFFFF_FFFC ||
            readLog[2] !== 32'h0000_0000) begin
            errors++;
            $display("[TB] FAIL wrap_addr: got %0d reads ending %h, expected fffffff8 fffffffc 00000000",
                     readLog.size(), readLog.size() > 0 ? readLog[readLog.size() - 1] : 32'hx);
        end
        checks++;
        if (writeDataLog.size() !== 3 || writeDataLog[2] !== expData[2]) begin
            errors++;
            $display("[TB] FAIL wrap_data: got %0d writes, expected 3 with wrapped word %h", writeDataLog.size(), expData[2]);
        end
        regRead(2'd0, d, v);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("[TB] FAIL wrap_src: got %h, expected 00000004", d);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] src;
            logic [31:0] dst;
            logic [31:0] d;
            logic v;
            int len;
            int lat;
            int cyc;
            int bad;
            src = {$urandom_range(32'hFFFF), 16'h0} | 32'(4 * $urandom_range(63));
            dst = src + 32'h0001_0000;
            len = $urandom_range(6, 1);
            lat = $urandom_range(3);
            fillSource(src, len);
            startCopy(src, dst, len, lat);
            waitIdle(500, cyc);
            checks++;
            if (reqCycles !== len * (lat + 2)) begin
                errors++;
                $display("[TB] FAIL rand%0d_cycles: got %0d, expected %0d", it, reqCycles, len * (lat + 2));
            end
            bad = 0;
            for (int i = 0; i < len; i++) begin
                if (i >= writeAddrLog.size() || i >= readLog.size() ||
                    readLog[i] !== src + 32'(4 * i) || writeAddrLog[i] !== dst + 32'(4 * i) ||
                    writeDataLog[i] !== expData[i] || mem[dst + 32'(4 * i)] !== expData[i]) bad++;
            end
            checks++;
            if (bad !== 0 || writeAddrLog.size() !== len) begin
                errors++;
                $display("[TB] FAIL rand%0d_words: got %0d bad of %0d writes, expected %0d clean", it, bad, writeAddrLog.size(), len);
            end
            regRead(2'd1, d, v);
            checks++;
            if (d !== dst + 32'(4 * len)) begin
                errors++;
                $display("[TB] FAIL rand%0d_dst: got %h, expected %h", it, d, dst + 32'(4 * len));
            end
        end
        checks++;
        if (selErrors !== 0) begin
            errors++;
            $display("[TB] FAIL sel_lanes: got %0d cycles without 4'b1111, expected 0", selErrors);
        end
    endtask

    task automatic test_irq;
        int cyc;
        ieBits = IRQ_EN ? 32'h8 : 32'h0;
        regWrite(2'd3, 32'h8, 4'hF);
        fillSource(32'h5000_0000, 2);
        startCopy(32'h5000_0000, 32'h5000_0100, 2, 1);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_busy: got %b, expected 0", irq_o);
        end
        waitIdle(200, cyc);
        checks++;
        if (irq_o !== IRQ_EN) begin
            errors++;
            $display("[TB] FAIL irq_done: got %b, expected %b", irq_o, IRQ_EN);
        end
        regWrite(2'd3, 32'h4 | ieBits, 4'hF);
        checks++;
        if (irq_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_clear: got %b, expected 0", irq_o);
        end
        ieBits = '0;
        regWrite(2'd3, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic v;
        fillSource(32'h6000_0000, 4);
        startCopy(32'h6000_0000, 32'h6000_0100, 4, 3);
        @(negedge clk_i);
        #2 n_rst_i = 1'b0;
        #1;
        checks++;
        if ({m_req_o, m_sel_o, m_addr_o, m_we_o, m_data_o, rvalid_o, data_o, irq_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got req=%b sel=%h addr=%h we=%b, expected all 0", m_req_o, m_sel_o, m_addr_o, m_we_o);
        end
        @(negedge clk_i);
        n_rst_i = 1'b1;
        regRead(2'd2, d, v);
        checks++;
        if (d !== 32'h0 || m_req_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_len: got len=%h req=%b, expected 0/0", d, m_req_o);
        end
    endtask

    initial begin
        $display("[TB] dma_copy bench start, DMA_IRQ_EN=%0d", IRQ_EN);
        test_reset;
        test_regport;
        test_copy;
        test_len_zero;
        test_busy_writes;
        test_abort;
        test_wrap;
        test_random;
        test_irq;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_copy.md
# dma_copy

Single-channel word-copy DMA engine for the SoC bus. Programmed by the core through a bus slave port (register block). Acts as an initiator on the same req/sel/addr/we/data/rvalid bus protocol the core's LSU uses, copying a block of 32-bit words from a source address to a destination address, so a second bus master (via arbitration) can move data without core involvement.

## Interface
- LEN_W, 16, width of the word-count register (max transfer 2^LEN_W-1 words)
- clk_i  in  1  system clock
- n_rst_i  in  1  asynchronous active-low reset
- ce_i  in  1  register-port access strobe (one cycle per access)
- sel_i  in  4  byte lanes for register writes
- addr_i  in  32  register address; only addr_i[3:2] decoded
- we_i  in  1  register write enable
- data_i  in  32  register write data
- rvalid_o  out  1  register access acknowledge
- data_o  out  32  register read data
- m_req_o  out  1  master request
- m_sel_o  out  4  master byte lanes; always 4'b1111 while m_req_o=1
- m_addr_o  out  32  master address
- m_we_o  out  1  master write enable
- m_data_o  out  32  master write data
- m_rvalid_i  in  1  master read data valid
- m_data_i  in  32  master read data
- irq_o  out  1  level interrupt, DONE & IE

## Operation
- Registers (addr_i[3:2]): 0 SRC, 1 DST, 2 LEN (LEN_W bits, zero-extended on read), 3 CTRL.
- CTRL bits: [0] START (write-1, reads 0), [1] BUSY (ro), [2] DONE (sticky, write-1-clear), [3] IE (rw), [4] ABORT (write-1, reads 0).
- SRC/DST bits [1:0] hard-wired 0. Writes honour sel_i byte lanes.
- SRC/DST/LEN read back live values: SRC/DST advance by 4 per word, LEN decrements per word.
- Writes to SRC/DST/LEN while BUSY ignored; START while BUSY ignored.
- START with LEN=0: DONE set next cycle, BUSY never set, no bus traffic.
- FSM: IDLE, RD, WR.
  - IDLE: on START with LEN!=0, go to RD with BUSY=1.
  - RD: m_req_o=1, m_we_o=0, m_addr_o=SRC, held stable until m_rvalid_i=1; m_data_i captured that cycle; then go to WR.
  - WR: m_req_o=1, m_we_o=1, m_addr_o=DST, m_data_o=captured word, for exactly one cycle. Then SRC+=4, DST+=4, LEN-=1. If new LEN=0, go to IDLE with BUSY=0 and DONE=1; otherwise go to RD.
- Address arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0.
- ABORT is latched while BUSY and takes effect only at the end of WR; an outstanding RD is never dropped. On abort: go to IDLE, BUSY=0, DONE not set, SRC/DST/LEN hold post-beat values. ABORT while IDLE has no effect.
- A DONE-clear write in the same cycle as hardware setting DONE: the set wins.

## Timing
- Reset: all outputs 0; SRC=DST=LEN=0, IE=DONE=BUSY=0, FSM=IDLE. A reset mid-transfer drops m_req_o immediately (asynchronous).
- Register port: rvalid_o pulses one cycle after every ce_i (read or write). data_o is registered and valid in that cycle; it is 0 when rvalid_o=0.
- START written at cycle T: BUSY=1 and m_req_o=1 at T+1.
- Per-word cost: (RD cycles up to and including m_rvalid_i) + 1 WR cycle. With 1-cycle read latency: 3 cycles/word.
- irq_o rises the cycle after the final WR beat.

## Configuration
- DMA_IRQ_EN defined: IE bit and irq_o function as above.
- DMA_IRQ_EN undefined: IE reads 0 and ignores writes; irq_o tied 0; DONE still operates for polling.

## Structure
- dma_pkg: register offset constants, CTRL bit positions, FSM state encoding.
- One sub-module: dma_regs, which holds register decode, sel_i masking, read mux and the rvalid_o pipeline. The FSM and address/count datapath stay in dma_copy.

## Test plan
- Copy: SRC=0x1000_0000, DST=0x1000_0100, LEN=4, read latency 1 -> 4 RD/WR pairs at +0,+4,+8,+C; DONE at cycle 12 after START; memory matches source.
- LEN=0 START -> no m_req_o ever; DONE=1 next cycle; BUSY stays 0.
- Read latency 5, plus START rewritten and SRC written while BUSY -> m_addr_o held stable for 5 cycles; writes ignored; LEN=2 transfer completes unaffected.
- ABORT written during RD of word 2 of 8 -> that word's read and write complete; then IDLE, DONE=0, LEN reads 6, SRC=base+8.
- SRC=0xFFFF_FFF8, LEN=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- DMA_IRQ_EN with IE=1 -> irq_o=1 after completion; W1C of DONE drops irq_o next cycle. Reset asserted mid-transfer -> all outputs 0 immediately.
